// File: rtl/cursor_motion.sv
// Cursor position writer: applies VT52 motion commands with edge clamping and
// hands off to the screen scroller when LF/RLF runs off the bottom/top row.
module cursor_motion #(
  parameter int ROW_BITS = 5,
  parameter int COL_BITS = 7,
  parameter int ROWS     = 24,
  parameter int COLS     = 80
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [3:0]          cmd_op,
  input  logic [ROW_BITS-1:0] cmd_row,
  input  logic [COL_BITS-1:0] cmd_col,
  output logic [COL_BITS-1:0] new_cursor_x,
  output logic [ROW_BITS-1:0] new_cursor_y,
  output logic                new_cursor_wen,
  output logic                scroll_req,
  output logic                scroll_dir,
  input  logic                scroll_ack
);

  localparam logic [COL_BITS-1:0] X_MAX = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0] Y_MAX = ROW_BITS'(ROWS - 1);

  localparam logic [3:0] OP_UP      = 4'd1;
  localparam logic [3:0] OP_DOWN    = 4'd2;
  localparam logic [3:0] OP_RIGHT   = 4'd3;
  localparam logic [3:0] OP_LEFT    = 4'd4;
  localparam logic [3:0] OP_HOME    = 4'd5;
  localparam logic [3:0] OP_CR      = 4'd6;
  localparam logic [3:0] OP_LF      = 4'd7;
  localparam logic [3:0] OP_RLF     = 4'd8;
  localparam logic [3:0] OP_TAB     = 4'd9;
  localparam logic [3:0] OP_ADVANCE = 4'd10;
  localparam logic [3:0] OP_SET     = 4'd11;

  typedef enum logic {IDLE, SCROLL} state_t;

  state_t              state_q, state_d;
  logic [COL_BITS-1:0] x_q, x_d;
  logic [ROW_BITS-1:0] y_q, y_d;
  logic                wen_q, wen_d;
  logic                req_q, req_d;
  logic                dir_q, dir_d;
  logic [COL_BITS:0]   tab_next;

  assign cmd_ready      = (state_q == IDLE) & reset;
  assign new_cursor_x   = x_q;
  assign new_cursor_y   = y_q;
  assign new_cursor_wen = wen_q;
  assign scroll_req     = req_q;
  assign scroll_dir     = dir_q;

  // One extra bit so that (x|7)+1 cannot wrap before it is clamped.
  assign tab_next = {1'b0, x_q | COL_BITS'(7)} + 1'b1;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    wen_d   = 1'b0;
    req_d   = req_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          wen_d = 1'b1;
          case (cmd_op)
            OP_UP:    y_d = (y_q > '0) ? y_q - 1'b1 : '0;
            OP_DOWN:  y_d = (y_q < Y_MAX) ? y_q + 1'b1 : Y_MAX;
            OP_RIGHT,
            OP_ADVANCE: x_d = (x_q < X_MAX) ? x_q + 1'b1 : X_MAX;
            OP_LEFT:  x_d = (x_q > '0) ? x_q - 1'b1 : '0;
            OP_HOME: begin
              x_d = '0;
              y_d = '0;
            end
            OP_CR:    x_d = '0;
            OP_TAB:   x_d = (tab_next > {1'b0, X_MAX}) ? X_MAX : tab_next[COL_BITS-1:0];
            OP_SET: begin
              x_d = (cmd_col > X_MAX) ? X_MAX : cmd_col;
              y_d = (cmd_row > Y_MAX) ? Y_MAX : cmd_row;
            end
            OP_LF: begin
              if (y_q < Y_MAX) begin
                y_d = y_q + 1'b1;
              end else begin
                wen_d   = 1'b0;
                state_d = SCROLL;
                req_d   = 1'b1;
                dir_d   = 1'b0;
              end
            end
            OP_RLF: begin
              if (y_q > '0) begin
                y_d = y_q - 1'b1;
              end else begin
                wen_d   = 1'b0;
                state_d = SCROLL;
                req_d   = 1'b1;
                dir_d   = 1'b1;
              end
            end
            default:  wen_d = 1'b0;
          endcase
        end
      end
      SCROLL: begin
        // The strobe after the ack re-arms the blink at the unchanged position.
        if (scroll_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          wen_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      wen_q   <= 1'b0;
      req_q   <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      wen_q   <= wen_d;
      req_q   <= req_d;
      dir_q   <= dir_d;
    end
  end

endmodule

// File: tb/tb_cursor_motion.sv
// Directed bench for cursor_motion: clamping, TAB stops, scroll handshake,
// asynchronous reset mid-scroll and back-to-back throughput.
`timescale 1ns/1ps
module tb_cursor_motion;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_op = 4'd0;
  logic [4:0] cmd_row = '0;
  logic [6:0] cmd_col = '0;
  logic [6:0] new_cursor_x;
  logic [4:0] new_cursor_y;
  logic       new_cursor_wen;
  logic       scroll_req;
  logic       scroll_dir;
  logic       scroll_ack = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cursor_motion dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_row        (cmd_row),
    .cmd_col        (cmd_col),
    .new_cursor_x   (new_cursor_x),
    .new_cursor_y   (new_cursor_y),
    .new_cursor_wen (new_cursor_wen),
    .scroll_req     (scroll_req),
    .scroll_dir     (scroll_dir),
    .scroll_ack     (scroll_ack)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command for one edge, then check the cycle after the accept.
  task automatic cmd(input string tag, input logic [3:0] op, input int row, input int col,
                     input int ex, input int ey, input int ewen);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_row   = 5'(row);
    cmd_col   = 7'(col);
    tick();
    cmd_valid = 1'b0;
    check({tag, ".x"}, int'(new_cursor_x), ex);
    check({tag, ".y"}, int'(new_cursor_y), ey);
    check({tag, ".wen"}, int'(new_cursor_wen), ewen);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with a command presented: nothing may happen.
    cmd_valid = 1'b1;
    cmd_op    = 4'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst.ready", int'(cmd_ready), 0);
      check("rst.wen", int'(new_cursor_wen), 0);
      check("rst.x", int'(new_cursor_x), 0);
    end
    cmd_valid = 1'b0;
    reset = 1'b1;
    tick();
    check("idle.ready", int'(cmd_ready), 1);
    check("idle.x", int'(new_cursor_x), 0);
    check("idle.y", int'(new_cursor_y), 0);
    check("idle.wen", int'(new_cursor_wen), 0);
    check("idle.req", int'(scroll_req), 0);
    check("idle.dir", int'(scroll_dir), 0);

    // Clamping
    cmd("set_clamp", 4'd11, 30, 100, 79, 23, 1);
    tick();
    check("set_clamp.one_strobe", int'(new_cursor_wen), 0);
    cmd("right_edge", 4'd3, 0, 0, 79, 23, 1);
    cmd("down_edge", 4'd2, 0, 0, 79, 23, 1);
    cmd("home", 4'd5, 0, 0, 0, 0, 1);
    cmd("up_top", 4'd1, 0, 0, 0, 0, 1);
    cmd("left_edge", 4'd4, 0, 0, 0, 0, 1);
    cmd("nop", 4'd0, 0, 0, 0, 0, 0);
    cmd("op13", 4'd13, 0, 0, 0, 0, 0);
    check("op13.ready", int'(cmd_ready), 1);

    // TAB stops from column 0
    for (int i = 1; i <= 9; i++) cmd($sformatf("tab%0d", i), 4'd9, 0, 0, 8 * i, 0, 1);
    cmd("tab_clamp1", 4'd9, 0, 0, 79, 0, 1);
    cmd("tab_clamp2", 4'd9, 0, 0, 79, 0, 1);
    cmd("set_x5", 4'd11, 2, 5, 5, 2, 1);
    cmd("tab_from5", 4'd9, 0, 0, 8, 2, 1);
    cmd("tab_from8", 4'd9, 0, 0, 16, 2, 1);
    cmd("cr", 4'd6, 0, 0, 0, 2, 1);
    cmd("down", 4'd2, 0, 0, 0, 3, 1);

    // Back-to-back RIGHT with cmd_valid held
    cmd("home2", 4'd5, 0, 0, 0, 0, 1);
    cmd_valid = 1'b1;
    cmd_op    = 4'd3;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("b2b%0d.x", i), int'(new_cursor_x), i);
      check($sformatf("b2b%0d.wen", i), int'(new_cursor_wen), 1);
    end
    cmd_valid = 1'b0;
    tick();
    check("b2b.end_wen", int'(new_cursor_wen), 0);

    // Stray ack in IDLE
    scroll_ack = 1'b1;
    tick();
    scroll_ack = 1'b0;
    check("stray.req", int'(scroll_req), 0);
    check("stray.wen", int'(new_cursor_wen), 0);
    check("stray.ready", int'(cmd_ready), 1);
    check("stray.x", int'(new_cursor_x), 4);

    // LF scroll handshake
    cmd("set_y22", 4'd11, 22, 10, 10, 22, 1);
    cmd("lf_to23", 4'd7, 0, 0, 10, 23, 1);
    cmd("lf_scroll", 4'd7, 0, 0, 10, 23, 0);
    check("lf_scroll.req", int'(scroll_req), 1);
    check("lf_scroll.dir", int'(scroll_dir), 0);
    check("lf_scroll.ready", int'(cmd_ready), 0);
    cmd_valid = 1'b1;
    cmd_op    = 4'd10;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("wait.req", int'(scroll_req), 1);
      check("wait.ready", int'(cmd_ready), 0);
      check("wait.x", int'(new_cursor_x), 10);
      check("wait.wen", int'(new_cursor_wen), 0);
    end
    scroll_ack = 1'b1;
    tick();
    scroll_ack = 1'b0;
    check("ack.req", int'(scroll_req), 0);
    check("ack.wen", int'(new_cursor_wen), 1);
    check("ack.x", int'(new_cursor_x), 10);
    check("ack.y", int'(new_cursor_y), 23);
    check("ack.ready", int'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
    check("adv.x", int'(new_cursor_x), 11);
    check("adv.wen", int'(new_cursor_wen), 1);
    tick();
    check("adv.end_wen", int'(new_cursor_wen), 0);

    // RLF at top row, then reset during the wait
    cmd("set_y0", 4'd11, 0, 3, 3, 0, 1);
    cmd("rlf_scroll", 4'd8, 0, 0, 3, 0, 0);
    check("rlf.req", int'(scroll_req), 1);
    check("rlf.dir", int'(scroll_dir), 1);
    tick();
    tick();
    check("rlf.hold", int'(scroll_req), 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst.req", int'(scroll_req), 0);
    check("arst.ready", int'(cmd_ready), 0);
    check("arst.x", int'(new_cursor_x), 0);
    check("arst.y", int'(new_cursor_y), 0);
    tick();
    reset = 1'b1;
    tick();
    check("post.ready", int'(cmd_ready), 1);
    check("post.req", int'(scroll_req), 0);
    check("post.x", int'(new_cursor_x), 0);
    check("post.y", int'(new_cursor_y), 0);
    cmd("post.rlf_move", 4'd2, 0, 0, 0, 1, 1);
    cmd("post.rlf", 4'd8, 0, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
